// File: rtl/pipe_arb_pkg.sv
// pipe_arb_pkg: shared state encoding, grant identifiers and counter width for the memory arbiter.
package pipe_arb_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;
    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_DM = 1'b1;
    localparam int CNT_W = 4;
endpackage

// File: rtl/pipe_arb_stats.sv
// pipe_arb_stats: free-running grant and stall-cycle counters, wrapping modulo 2^32.
module pipe_arb_stats (
    input  logic        clock,
    input  logic        resetn,
    input  logic        if_grant,
    input  logic        dm_grant,
    input  logic        stall,
    output logic [31:0] stat_if_grants,
    output logic [31:0] stat_dm_grants,
    output logic [31:0] stat_stall_cycles
);
    logic [31:0] r_if, r_dm, r_stall;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_if    <= '0;
            r_dm    <= '0;
            r_stall <= '0;
        end else begin
            r_if    <= r_if + 32'(if_grant);
            r_dm    <= r_dm + 32'(dm_grant);
            r_stall <= r_stall + 32'(stall);
        end
    end

    assign stat_if_grants    = r_if;
    assign stat_dm_grants    = r_dm;
    assign stat_stall_cycles = r_stall;
endmodule

// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: shares one single-port memory between instruction fetch and data access.
// Define PIPE_MEM_ARBITER_STATS_EN to add grant and stall-cycle counter outputs.
module pipe_mem_arbiter
    import pipe_arb_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall
`ifdef PIPE_MEM_ARBITER_STATS_EN
    ,
    output logic [31:0]   stat_if_grants,
    output logic [31:0]   stat_dm_grants,
    output logic [31:0]   stat_stall_cycles
`endif
);
    state_t           r_state, w_next;
    logic             r_gnt, r_we;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata, r_if_rdata, r_dm_rdata;
    logic [CNT_W-1:0] r_cnt;
    logic             w_grant, w_gnt, w_last;

    assign w_grant = (r_state == IDLE) && (if_req || dm_req);
    // r_gnt doubles as last_grant: with both pending, the port that did not win last goes next.
    assign w_gnt   = (if_req && dm_req) ? ~r_gnt : (dm_req ? GNT_DM : GNT_IF);
    assign w_last  = (r_state == WAIT) && (r_cnt == CNT_W'(1));

    always_comb begin
        w_next = (r_state == IDLE)  ? (w_grant ? ISSUE : IDLE) :
                 (r_state == ISSUE) ? WAIT :
                 (r_state == WAIT)  ? (w_last ? RESP : WAIT) : IDLE;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_gnt      <= GNT_IF;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_gnt   <= w_gnt;
                r_we    <= (w_gnt == GNT_DM) && dm_we;
                r_addr  <= (w_gnt == GNT_DM) ? dm_addr : if_addr;
                r_wdata <= dm_wdata;
            end
            r_cnt <= (r_state == ISSUE) ? CNT_W'(LATENCY) : (r_state == WAIT) ? r_cnt - 1'b1 : r_cnt;
            if (w_last && !r_we && r_gnt == GNT_IF) r_if_rdata <= mem_rdata;
            if (w_last && !r_we && r_gnt == GNT_DM) r_dm_rdata <= mem_rdata;
        end
    end

    assign mem_en    = (r_state == ISSUE);
    assign mem_we    = mem_en && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_ready  = (r_state == RESP) && (r_gnt == GNT_IF);
    assign dm_ready  = (r_state == RESP) && (r_gnt == GNT_DM);
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign stall     = (if_req && !if_ready) || (dm_req && !dm_ready);

`ifdef PIPE_MEM_ARBITER_STATS_EN
    pipe_arb_stats u_stats (
        .clock             (clock),
        .resetn            (resetn),
        .if_grant          (w_grant && w_gnt == GNT_IF),
        .dm_grant          (w_grant && w_gnt == GNT_DM),
        .stall             (stall),
        .stat_if_grants    (stat_if_grants),
        .stat_dm_grants    (stat_dm_grants),
        .stat_stall_cycles (stat_stall_cycles)
    );
`endif
endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// tb_pipe_mem_arbiter: two arbiter instances (LATENCY 1 and 4) with behavioural memories and a timeline reference model.
module tb_pipe_mem_arbiter;
    localparam int LAT0 = 1;
    localparam int LAT1 = 4;

    typedef struct packed {
        logic        dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetn [2];
    logic        if_req [2], dm_req [2], dm_we [2];
    logic        if_ready [2], dm_ready [2], mem_en [2], mem_we [2], stall [2];
    logic [31:0] if_addr [2], dm_addr [2], dm_wdata [2];
    logic [31:0] if_rdata [2], dm_rdata [2], mem_addr [2], mem_wdata [2], mem_rdata [2];
`ifdef PIPE_MEM_ARBITER_STATS_EN
    logic [31:0] st_if [2], st_dm [2], st_stall [2];
`endif
    logic        mem_clr;

    int          checks = 0;
    int          failures = 0;
    int          exp_stall_cycles = 0;
    logic [31:0] ref_mem [256];

    function automatic logic [31:0] init_word(input logic [7:0] i);
        return 32'h8C21_FFF4 + {24'h0, i};
    endfunction

    function automatic int lat(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = (g == 0) ? LAT0 : LAT1;
        logic [31:0]  wm [256];
        logic [255:0] wr;
        logic [3:0]   cnt;
        logic [31:0]  d;
        logic [7:0]   idx;
        assign idx = mem_addr[g][9:2];

        pipe_mem_arbiter #(.LATENCY(L), .AW(32), .DW(32)) u_dut (
            .clock     (clock),
            .resetn    (resetn[g]),
            .if_req    (if_req[g]),
            .if_addr   (if_addr[g]),
            .if_rdata  (if_rdata[g]),
            .if_ready  (if_ready[g]),
            .dm_req    (dm_req[g]),
            .dm_we     (dm_we[g]),
            .dm_addr   (dm_addr[g]),
            .dm_wdata  (dm_wdata[g]),
            .dm_rdata  (dm_rdata[g]),
            .dm_ready  (dm_ready[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g]),
            .stall     (stall[g])
`ifdef PIPE_MEM_ARBITER_STATS_EN
            ,
            .stat_if_grants    (st_if[g]),
            .stat_dm_grants    (st_dm[g]),
            .stat_stall_cycles (st_stall[g])
`endif
        );

        // Read data is presented only in the single cycle that ends L edges after the issue edge.
        always @(posedge clock) begin
            if (mem_clr) begin
                wr  <= '0;
                cnt <= 4'hF;
            end else if (mem_en[g]) begin
                cnt <= 4'd1;
                if (mem_we[g]) begin
                    wm[idx] <= mem_wdata[g];
                    wr[idx] <= 1'b1;
                end else begin
                    d <= wr[idx] ? wm[idx] : init_word(idx);
                end
            end else if (cnt != 4'hF) begin
                cnt <= cnt + 4'd1;
            end
        end
        assign mem_rdata[g] = (cnt == 4'(L)) ? d : 32'hBAD0_0000;
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input int k);
        @(posedge clock); #1;
        resetn[k] = 1'b0;
        if_req[k] = 1'b0;
        dm_req[k] = 1'b0;
        dm_we[k]  = 1'b0;
        repeat (2) @(posedge clock);
        #1 resetn[k] = 1'b1;
    endtask

    // One transaction on one port; fields are scrambled after the grant to show they were latched.
    task automatic do_txn(input int k, input logic dm, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rd);
        int   n;
        logic rdy;
        n  = -1;
        rd = 32'hX;
        @(posedge clock); #1;
        if (dm) begin
            dm_req[k] = 1'b1; dm_we[k] = we; dm_addr[k] = addr; dm_wdata[k] = wdata;
        end else begin
            if_req[k] = 1'b1; if_addr[k] = addr;
        end
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin
                @(posedge clock); #1;
                if_addr[k] = $urandom; dm_addr[k] = $urandom; dm_wdata[k] = $urandom; dm_we[k] = ~we;
            end
            @(negedge clock);
            rdy = dm ? dm_ready[k] : if_ready[k];
            if (mem_en[k]) begin
                chkn("txn_issue_cycle", c, 1);
                chk32("txn_mem_addr", mem_addr[k], addr);
                chk1("txn_mem_we", mem_we[k], we);
                if (we) chk32("txn_mem_wdata", mem_wdata[k], wdata);
            end
            chk1("txn_stall", stall[k], !rdy);
            if (!rdy) exp_stall_cycles++;
            if (rdy) begin
                n  = c;
                rd = dm ? dm_rdata[k] : if_rdata[k];
                break;
            end
        end
        chkn("txn_latency", n, lat(k) + 2);
        @(posedge clock); #1;
        if_req[k] = 1'b0;
        dm_req[k] = 1'b0;
        if (k == 0 && we) ref_mem[addr[9:2]] = wdata;
    endtask

    vec_t        tbl [9];
    logic [31:0] rd;
    int          dm_c, if_c, en_cnt, done;
    logic        prev_en;
    logic        busy, g_dm, g_we, last_dm, ireq, dreq, i_gr, d_gr, d_we_r;
    int          t_iss, t_rsp;
    logic [31:0] g_addr, g_wdata, g_rd, i_addr_r, d_addr_r, d_wdata_r;
    logic        e_en, e_ir, e_dr;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
        for (int k = 0; k < 2; k++) begin
            resetn[k] = 1'b0; if_req[k] = 1'b0; dm_req[k] = 1'b0; dm_we[k] = 1'b0;
            if_addr[k] = '0; dm_addr[k] = '0; dm_wdata[k] = '0;
        end
        mem_clr = 1'b1;
        @(posedge clock); #1 mem_clr = 1'b0;
        @(negedge clock);
        chk1("rst_mem_en", mem_en[0], 1'b0);
        chk1("rst_if_ready", if_ready[0], 1'b0);
        chk1("rst_dm_ready", dm_ready[0], 1'b0);
        chk32("rst_mem_addr", mem_addr[0], 32'h0);
        chk32("rst_if_rdata", if_rdata[0], 32'h0);
        chk32("rst_dm_rdata", dm_rdata[0], 32'h0);
        do_reset(0);
        do_reset(1);

        // Single fetch, cycle by cycle.
        @(posedge clock); #1;
        if_req[0] = 1'b1; if_addr[0] = 32'h40;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin @(posedge clock); #1; end
            @(negedge clock);
            chk1($sformatf("t1_mem_en_c%0d", c), mem_en[0], c == 1);
            if (c == 1) begin
                chk32("t1_mem_addr", mem_addr[0], 32'h40);
                chk1("t1_mem_we", mem_we[0], 1'b0);
            end
            chk1($sformatf("t1_stall_c%0d", c), stall[0], c < 3);
            chk1($sformatf("t1_if_ready_c%0d", c), if_ready[0], c == 3);
            if (c == 3) chk32("t1_if_rdata", if_rdata[0], 32'h8C22_0004);
        end
        @(posedge clock); #1 if_req[0] = 1'b0;

        // Table of single transactions with expected read data.
        tbl[0] = '{1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF};
        tbl[2] = '{1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF};
        tbl[3] = '{1'b0, 1'b0, 32'h40, 32'h0, 32'h8C22_0004};
        tbl[4] = '{1'b1, 1'b1, 32'h80, 32'h1234_5678, 32'h0};
        tbl[5] = '{1'b0, 1'b0, 32'h80, 32'h0, 32'h1234_5678};
        tbl[6] = '{1'b1, 1'b0, 32'h84, 32'h0, 32'h8C22_0015};
        tbl[7] = '{1'b1, 1'b1, 32'h10, 32'h0, 32'h0};
        tbl[8] = '{1'b1, 1'b0, 32'h10, 32'h0, 32'h0};
        for (int i = 0; i < 9; i++) begin
            do_txn(0, tbl[i].dm, tbl[i].we, tbl[i].addr, tbl[i].wdata, rd);
            if (!tbl[i].we) chk32($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp);
        end

        // Both ports right after reset: data first, then fetch.
        do_reset(0);
        @(posedge clock); #1;
        if_req[0] = 1'b1; if_addr[0] = 32'h44;
        dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 32'h48;
        dm_c = -1; if_c = -1; en_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) begin
                @(posedge clock); #1;
                if (dm_c >= 0) dm_req[0] = 1'b0;
                if (if_c >= 0) if_req[0] = 1'b0;
            end
            @(negedge clock);
            if (mem_en[0]) en_cnt++;
            if (dm_ready[0] && dm_c < 0) begin
                dm_c = c;
                chk32("t2_dm_rdata", dm_rdata[0], ref_mem[18]);
            end
            if (if_ready[0] && if_c < 0) begin
                if_c = c;
                chk32("t2_if_rdata", if_rdata[0], ref_mem[17]);
            end
        end
        chkn("t2_dm_ready_cycle", dm_c, 3);
        chkn("t2_if_ready_cycle", if_c, 7);
        chkn("t2_mem_en_pulses", en_cnt, 2);

        // Both held for six transactions: grants alternate starting with data.
        do_reset(0);
        @(posedge clock); #1;
        if_req[0] = 1'b1; if_addr[0] = 32'h4;
        dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 32'h8;
        done = 0; prev_en = 1'b0;
        for (int c = 0; c < 80 && done < 6; c++) begin
            if (c > 0) begin @(posedge clock); #1; end
            @(negedge clock);
            chk1("t3_en_gap", mem_en[0] && prev_en, 1'b0);
            prev_en = mem_en[0];
            if (dm_ready[0] || if_ready[0]) begin
                chk1($sformatf("t3_grant%0d_is_dm", done), dm_ready[0], (done % 2) == 0);
                done++;
            end
        end
        chkn("t3_count", done, 6);
        @(posedge clock); #1;
        if_req[0] = 1'b0; dm_req[0] = 1'b0;

        // LATENCY=4 instance: reset during WAIT abandons the access.
        do_txn(1, 1'b1, 1'b0, 32'h20, 32'h0, rd);
        chk32("t5_first_rdata", rd, init_word(8'd8));
        @(posedge clock); #1;
        dm_req[1] = 1'b1; dm_we[1] = 1'b0; dm_addr[1] = 32'h24;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin @(posedge clock); #1; end
            @(negedge clock);
            chk1($sformatf("t5_mem_en_c%0d", c), mem_en[1], c == 1);
        end
        resetn[1] = 1'b0;
        #1;
        chk1("t5_rst_mem_en", mem_en[1], 1'b0);
        chk1("t5_rst_mem_we", mem_we[1], 1'b0);
        chk1("t5_rst_dm_ready", dm_ready[1], 1'b0);
        chk1("t5_rst_if_ready", if_ready[1], 1'b0);
        chk32("t5_rst_mem_addr", mem_addr[1], 32'h0);
        chk32("t5_rst_mem_wdata", mem_wdata[1], 32'h0);
        chk32("t5_rst_dm_rdata", dm_rdata[1], 32'h0);
        chk32("t5_rst_if_rdata", if_rdata[1], 32'h0);
        dm_req[1] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock); #1;
            if (c == 2) resetn[1] = 1'b1;
            @(negedge clock);
            chk1("t5_no_ready", dm_ready[1], 1'b0);
            chk1("t5_idle_no_en", mem_en[1], 1'b0);
        end
        do_txn(1, 1'b1, 1'b0, 32'h28, 32'h0, rd);
        chk32("t5_after_rdata", rd, init_word(8'd10));

        // Random traffic on the LATENCY=1 instance against a timeline model.
        do_reset(0);
        busy = 1'b0; last_dm = 1'b0; ireq = 1'b0; dreq = 1'b0; i_gr = 1'b0; d_gr = 1'b0;
        t_iss = -1; t_rsp = -1; g_dm = 1'b0; g_we = 1'b0;
        g_addr = '0; g_wdata = '0; g_rd = '0;
        i_addr_r = '0; d_addr_r = '0; d_wdata_r = '0; d_we_r = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clock); #1;
            if_req[0]   = ireq;
            if_addr[0]  = i_gr ? $urandom : i_addr_r;
            dm_req[0]   = dreq;
            dm_addr[0]  = d_gr ? $urandom : d_addr_r;
            dm_wdata[0] = d_gr ? $urandom : d_wdata_r;
            dm_we[0]    = d_gr ? 1'($urandom_range(0, 1)) : d_we_r;
            @(negedge clock);
            e_en = busy && n == t_iss;
            e_ir = busy && n == t_rsp && !g_dm;
            e_dr = busy && n == t_rsp && g_dm;
            chk1("rnd_mem_en", mem_en[0], e_en);
            chk1("rnd_if_ready", if_ready[0], e_ir);
            chk1("rnd_dm_ready", dm_ready[0], e_dr);
            chk1("rnd_stall", stall[0], (ireq && !e_ir) || (dreq && !e_dr));
            if (e_en && mem_en[0]) begin
                chk32("rnd_mem_addr", mem_addr[0], g_addr);
                chk1("rnd_mem_we", mem_we[0], g_we);
                if (g_we) chk32("rnd_mem_wdata", mem_wdata[0], g_wdata);
            end
            if (e_ir && !g_we) chk32("rnd_if_rdata", if_rdata[0], g_rd);
            if (e_dr && !g_we) chk32("rnd_dm_rdata", dm_rdata[0], g_rd);
            if (busy && n == t_rsp) begin
                busy = 1'b0;
                if (g_dm) begin dreq = 1'b0; d_gr = 1'b0; end
                else begin ireq = 1'b0; i_gr = 1'b0; end
            end else if (!busy && (ireq || dreq)) begin
                g_dm    = (ireq && dreq) ? !last_dm : dreq;
                last_dm = g_dm;
                busy    = 1'b1;
                t_iss   = n + 1;
                t_rsp   = n + LAT0 + 2;
                g_addr  = g_dm ? d_addr_r : i_addr_r;
                g_we    = g_dm && d_we_r;
                g_wdata = d_wdata_r;
                if (g_dm) d_gr = 1'b1; else i_gr = 1'b1;
                if (g_we) ref_mem[g_addr[9:2]] = g_wdata;
                else g_rd = ref_mem[g_addr[9:2]];
            end
            if (!ireq && $urandom_range(0, 2) == 0) begin
                ireq = 1'b1;
                i_addr_r = {22'h0, 4'h0, 4'($urandom_range(0, 15)), 2'b00};
            end
            if (!dreq && $urandom_range(0, 2) == 0) begin
                dreq = 1'b1;
                d_addr_r  = {22'h0, 4'h0, 4'($urandom_range(0, 15)), 2'b00};
                d_we_r    = 1'($urandom_range(0, 1));
                d_wdata_r = $urandom;
            end
        end
        @(posedge clock); #1;
        if_req[0] = 1'b0; dm_req[0] = 1'b0;

`ifdef PIPE_MEM_ARBITER_STATS_EN
        do_reset(0);
        exp_stall_cycles = 0;
        for (int i = 0; i < 3; i++) do_txn(0, 1'b0, 1'b0, 32'(i * 4), 32'h0, rd);
        for (int i = 0; i < 2; i++) do_txn(0, 1'b1, 1'b0, 32'(i * 4 + 32), 32'h0, rd);
        @(negedge clock);
        chk32("stat_if_grants", st_if[0], 32'd3);
        chk32("stat_dm_grants", st_dm[0], 32'd2);
        chk32("stat_stall_cycles", st_stall[0], 32'(exp_stall_cycles));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
